mac_stream: RTL and testbench

MAC_STREAM -- requirements
Module: mac_stream

---
 rtl/mac_stream.sv | 183 ++++++++++++++++++
 tb/tb_mac_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream.sv
// -----------------------------------------------------------------------------
// mac_stream
// Streaming fixed-point multiply-accumulate. Each frame consumes N_TAPS
// data/weight pairs, adds a bias (sampled with the first tap), then presents
// one saturated (optionally ReLU-clamped) result until the consumer takes it.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous frame abort, highest priority
//   relu_en    : clamp negative results to zero (sampled with first tap)
//   in_valid   : tap valid
//   in_ready   : block can accept a tap (ACC state)
//   d, w       : data sample and weight, signed Q(DW-FRAC).FRAC
//   b          : bias, same format (sampled with first tap)
//   out_valid  : result valid (HOLD state)
//   out_ready  : consumer accepts the result
//   res        : saturated result, same format as the operands
//   tap_cnt    : taps accepted in the current frame
// -----------------------------------------------------------------------------
module mac_stream #(
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned N_TAPS = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 d,
  input  logic [DW-1:0]                 w,
  input  logic [DW-1:0]                 b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW-1:0]                 res,
  output logic [$clog2(N_TAPS+1)-1:0]   tap_cnt
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = $clog2(N_TAPS + 1);
  localparam int unsigned AW = PW + CW;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  relu_q, relu_d;
  logic [DW-1:0]         res_q, res_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  armed_q;

  logic                  accept;
  logic                  first_tap;
  logic                  last_tap;
  logic                  relu_eff;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  bias_ext;
  logic signed [AW-1:0]  acc_nxt;
  logic signed [AW-1:0]  acc_sh;
  logic signed [AW-1:0]  sat_max;
  logic signed [AW-1:0]  sat_min;
  logic [DW-1:0]         res_new;

  // Datapath: full-width product, bias alignment, running sum, final scaling.
  always_comb begin
    prod     = $signed(d) * $signed(w);
    bias_ext = AW'($signed(b)) <<< FRAC;
    acc_nxt  = (first_tap ? bias_ext : acc_q) + AW'(prod);
    acc_sh   = acc_nxt >>> FRAC;

    sat_max          = '0;
    sat_max[DW-2:0]  = '1;
    sat_min          = '1;
    sat_min[DW-2:0]  = '0;

    if (relu_eff && acc_sh < 0) begin
      res_new = '0;
    end else if (acc_sh > sat_max) begin
      res_new = DW'(sat_max);
    end else if (acc_sh < sat_min) begin
      res_new = DW'(sat_min);
    end else begin
      res_new = DW'(acc_sh);
    end
  end

  // armed_q blocks tap acceptance on the reset-release edge.
  assign accept    = in_valid && in_ready_q && armed_q;
  assign first_tap = (cnt_q == '0);
  assign last_tap  = (cnt_q == CW'(N_TAPS - 1));
  // With a single-tap frame the ReLU control must come straight from the port.
  assign relu_eff  = first_tap ? relu_en : relu_q;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    relu_d      = relu_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = ACC;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (first_tap) begin
              relu_d = relu_en;
            end
            if (last_tap) begin
              state_d     = HOLD;
              res_d       = res_new;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d     = ACC;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ACC;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      relu_q      <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      relu_q      <= relu_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      armed_q     <= 1'b1;
    end
  end

  // Accumulator needs no reset: the first tap of every frame overwrites it,
  // and the bias is folded in at that point.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign tap_cnt   = cnt_q;

endmodule

// File: tb/tb_mac_stream.sv
// -----------------------------------------------------------------------------
// tb_mac_stream
// Directed bench for mac_stream (DW=16, FRAC=8, N_TAPS=9). Expected results
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mac_stream;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          relu_en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d;
  logic [DW-1:0] w;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] res;
  logic [CW-1:0] tap_cnt;

  int n_vec;
  int n_err;

  mac_stream #(.DW(16), .FRAC(8), .N_TAPS(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .w         (w),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .tap_cnt   (tap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one tap; gap cycles of in_valid=0 precede it.
  task automatic push_tap(input logic [DW-1:0] dv, input logic [DW-1:0] wv, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      d        = 16'hDEAD;
      w        = 16'hBEEF;
      tick();
    end
    in_valid = 1'b1;
    d        = dv;
    w        = wv;
    tick();
    in_valid = 1'b0;
  endtask

  // Full frame; bias/relu are scrambled after the first tap to prove they are
  // only sampled once per frame.
  task automatic run_frame(input string tag, input logic [DW-1:0] dv, input logic [DW-1:0] wv,
                           input logic [DW-1:0] bv, input logic rv, input logic gaps,
                           input logic [DW-1:0] exp_res);
    for (int i = 0; i < 9; i++) begin
      b       = (i == 0) ? bv : 16'h5A5A;
      relu_en = (i == 0) ? rv : ~rv;
      push_tap(dv, wv, gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == 7) check({tag, "_cnt8"}, 32'(tap_cnt), 32'd8);
    end
    check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
    check({tag, "_iready"}, 32'(in_ready), 32'd0);
    check({tag, "_cnt9"}, 32'(tap_cnt), 32'd9);
    check({tag, "_res"}, 32'(res), 32'(exp_res));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    check({tag, "_ir_after"}, 32'(in_ready), 32'd1);
    check({tag, "_cnt_after"}, 32'(tap_cnt), 32'd0);
  endtask

  logic [DW-1:0] held;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    d         = '0;
    w         = '0;
    b         = '0;
    out_ready = 1'b0;
    #12;
    check("rst_cnt", 32'(tap_cnt), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    check("rst_res", 32'(res), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic 1.0*1.0 * 9 taps.
    run_frame("basic", 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0900);
    consume("basic");

    // Saturation both ways.
    run_frame("satp", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'h7FFF);
    consume("satp");
    run_frame("satn", 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 16'h8000);
    consume("satn");

    // Negative result, without and with ReLU.
    run_frame("neg", 16'h0100, 16'hFF00, 16'h0000, 1'b0, 1'b0, 16'hF700);
    consume("neg");
    run_frame("relu", 16'h0100, 16'hFF00, 16'h0000, 1'b1, 1'b0, 16'h0000);
    consume("relu");

    // Gaps between taps, then back-pressure for 5 cycles with taps offered.
    run_frame("gap", 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0900);
    held     = res;
    in_valid = 1'b1;
    d        = 16'h7FFF;
    w        = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_res", 32'(res), 32'(held));
      check("hold_ovalid", 32'(out_valid), 32'd1);
      check("hold_iready", 32'(in_ready), 32'd0);
      check("hold_cnt", 32'(tap_cnt), 32'd9);
    end
    in_valid = 1'b0;
    consume("gap");
    // Result must not reappear: single transfer only.
    tick();
    check("gap_single", 32'(out_valid), 32'd0);

    // Async reset mid-frame; taps offered across the release edge are ignored.
    for (int i = 0; i < 4; i++) begin
      b = 16'h7FFF;
      push_tap(16'h7FFF, 16'h7FFF, 0);
    end
    check("pre_rst_cnt", 32'(tap_cnt), 32'd4);
    rst_n = 1'b0;
    #1;
    check("async_cnt", 32'(tap_cnt), 32'd0);
    check("async_iready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b1;
    d        = 16'h7FFF;
    w        = 16'h7FFF;
    rst_n    = 1'b1;
    tick();
    check("release_no_accept", 32'(tap_cnt), 32'd0);
    in_valid = 1'b0;
    run_frame("post_rst", 16'h0200, 16'h0080, 16'h0100, 1'b0, 1'b0, 16'h0A00);
    consume("post_rst");

    // clr after 5 taps, with a tap offered in the clr cycle.
    for (int i = 0; i < 5; i++) begin
      push_tap(16'h7FFF, 16'h7FFF, 0);
    end
    clr      = 1'b1;
    in_valid = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_mid_cnt", 32'(tap_cnt), 32'd0);
    check("clr_mid_ov", 32'(out_valid), 32'd0);
    run_frame("after_clr", 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0900);

    // clr while holding a result (out_ready also high: clr wins).
    clr       = 1'b1;
    out_ready = 1'b1;
    tick();
    clr       = 1'b0;
    out_ready = 1'b0;
    check("clr_hold_cnt", 32'(tap_cnt), 32'd0);
    check("clr_hold_ov", 32'(out_valid), 32'd0);
    check("clr_hold_ir", 32'(in_ready), 32'd1);
    run_frame("after_clr2", 16'h0200, 16'h0080, 16'h0100, 1'b0, 1'b0, 16'h0A00);
    consume("after_clr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
